// File: rtl/vend_pkg.sv
// Shared constants for the vending credit controller: coin codes, coin values,
// controller states and the default credit ceiling.
package vend_pkg;

  localparam logic [1:0] COIN_PENNY   = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  localparam logic [4:0] VAL_PENNY   = 5'd1;
  localparam logic [4:0] VAL_NICKEL  = 5'd5;
  localparam logic [4:0] VAL_DIME    = 5'd10;
  localparam logic [4:0] VAL_QUARTER = 5'd25;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] CHANGE  = 1'b1;

  localparam int unsigned MAX_CREDIT_DEF = 500;

endpackage

// File: rtl/vend_credit_ctrl_coin_value.sv
// Combinational decode of a coin code to its value in cents.
module coin_value
  import vend_pkg::*;
(
  input  logic [1:0] coin_type_i,
  output logic [4:0] value_o
);

  // Map each denomination code to cents.
  always_comb begin
    value_o = 5'd0;
    case (coin_type_i)
      COIN_PENNY:   value_o = VAL_PENNY;
      COIN_NICKEL:  value_o = VAL_NICKEL;
      COIN_DIME:    value_o = VAL_DIME;
      COIN_QUARTER: value_o = VAL_QUARTER;
      default:      value_o = 5'd0;
    endcase
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit accumulator and sale controller feeding the change dispenser.
// Optional audit counters (sales_total, vend_count) are enabled by VEND_AUDIT_EN.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int unsigned CREDIT_W   = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic [CREDIT_W-1:0] price,
  input  logic                select,
  input  logic                cancel,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                deny,
  output logic                vend,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                busy
`ifdef VEND_AUDIT_EN
  ,
  output logic [15:0]         sales_total,
  output logic [7:0]          vend_count
`endif
);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  logic [0:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                cv_q, cv_d;
  logic                vend_q, vend_d;
  logic                deny_q, deny_d;
  logic                rej_q, rej_d;
  logic [4:0]          coin_val_s;
  logic [CREDIT_W:0]   sum_s;

  coin_value u_coin_value (
    .coin_type_i (coin_type),
    .value_o     (coin_val_s)
  );

  // One extra bit so an overflowing sum is still compared correctly.
  assign sum_s = {1'b0, credit_q} + {{(CREDIT_W-4){1'b0}}, coin_val_s};

  // Next-state logic; in COLLECT the priority is cancel > select > coin.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    cv_d     = cv_q;
    vend_d   = 1'b0;
    deny_d   = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (cancel && (credit_q != {CREDIT_W{1'b0}})) begin
          change_d = credit_q;
          credit_d = {CREDIT_W{1'b0}};
          state_d  = CHANGE;
          cv_d     = 1'b1;
          rej_d    = coin_valid;
        end else if (select && (credit_q >= price)) begin
          vend_d   = 1'b1;
          change_d = credit_q - price;
          credit_d = {CREDIT_W{1'b0}};
          state_d  = CHANGE;
          cv_d     = 1'b1;
          rej_d    = coin_valid;
        end else begin
          // A denied select does not block a coin arriving in the same cycle.
          deny_d = select;
          if (coin_valid) begin
            if (sum_s <= MAX_C) begin
              credit_d = sum_s[CREDIT_W-1:0];
            end else begin
              rej_d = 1'b1;
            end
          end else begin
            rej_d = 1'b0;
          end
        end
      end
      CHANGE: begin
        rej_d = coin_valid;
        if (change_ready) begin
          state_d = COLLECT;
          cv_d    = 1'b0;
        end else begin
          cv_d = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT;
        cv_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      credit_q <= {CREDIT_W{1'b0}};
      change_q <= {CREDIT_W{1'b0}};
      cv_q     <= 1'b0;
      vend_q   <= 1'b0;
      deny_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      cv_q     <= cv_d;
      vend_q   <= vend_d;
      deny_q   <= deny_d;
      rej_q    <= rej_d;
    end
  end

  assign credit       = credit_q;
  assign change       = change_q;
  assign change_valid = cv_q;
  assign vend         = vend_q;
  assign deny         = deny_q;
  assign coin_reject  = rej_q;
  assign busy         = (state_q == CHANGE);

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_q;
  logic [7:0]  count_q;
  logic [16:0] sales_sum_s;

  assign sales_sum_s = {1'b0, sales_q} + {{(17-CREDIT_W){1'b0}}, price};

  // Audit counters: saturating sales total, wrapping vend count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sales_q <= 16'd0;
      count_q <= 8'd0;
    end else if (vend_d) begin
      sales_q <= sales_sum_s[16] ? 16'hFFFF : sales_sum_s[15:0];
      count_q <= count_q + 8'd1;
    end else begin
      sales_q <= sales_q;
      count_q <= count_q;
    end
  end

  assign sales_total = sales_q;
  assign vend_count  = count_q;
`endif

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares them when the DUT emits an event.
module tb_vend_credit_ctrl;

  typedef struct packed {
    logic       rej;
    logic       den;
    logic       vnd;
    logic       cv;
    logic [8:0] chg;
    logic [8:0] cred;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic [8:0] price = 9'd0;
  logic       select = 1'b0;
  logic       cancel = 1'b0;
  logic       change_ready = 1'b0;
  logic [8:0] credit;
  logic       coin_reject, deny, vend, change_valid, busy;
  logic [8:0] change;
`ifdef VEND_AUDIT_EN
  logic [15:0] sales_total;
  logic [7:0]  vend_count;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic cv_prev = 1'b0;

  vend_credit_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .price        (price),
    .select       (select),
    .cancel       (cancel),
    .change_ready (change_ready),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .deny         (deny),
    .vend         (vend),
    .change       (change),
    .change_valid (change_valid),
    .busy         (busy)
`ifdef VEND_AUDIT_EN
    ,
    .sales_total  (sales_total),
    .vend_count   (vend_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    cyc();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [8:0] p);
    select = 1'b1;
    price  = p;
    cyc();
    select = 1'b0;
  endtask

  function automatic exp_t mk(logic r, logic d, logic v, logic c, logic [8:0] chg, logic [8:0] cred);
    exp_t e;
    e.rej = r; e.den = d; e.vnd = v; e.cv = c; e.chg = chg; e.cred = cred;
    return e;
  endfunction

  // Monitor: any pulse or a rising change_valid consumes one expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (coin_reject || deny || vend || (change_valid && !cv_prev))) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event rej %0b deny %0b vend %0b cv %0b", coin_reject, deny, vend, change_valid);
        end else begin
          e = sb_q.pop_front();
          cmp("ev_reject", 16'(coin_reject), 16'(e.rej));
          cmp("ev_deny", 16'(deny), 16'(e.den));
          cmp("ev_vend", 16'(vend), 16'(e.vnd));
          cmp("ev_change_valid", 16'(change_valid), 16'(e.cv));
          cmp("ev_credit", 16'(credit), 16'(e.cred));
          if (e.cv) cmp("ev_change", 16'(change), 16'(e.chg));
        end
      end
      cv_prev = change_valid;
    end
  end

  initial begin
    cyc();
    cmp("rst_credit", 16'(credit), 16'd0);
    cmp("rst_change_valid", 16'(change_valid), 16'd0);
    cmp("rst_busy", 16'(busy), 16'd0);
    cmp("rst_change", 16'(change), 16'd0);
    cmp("rst_pulses", 16'({vend, deny, coin_reject}), 16'd0);
    rst_n = 1'b1;
    cyc();

    // Normal sale with 5 cycles of backpressure and rejected coins.
    coin(2'b11); coin(2'b10); coin(2'b10); coin(2'b00);
    cmp("credit_46", 16'(credit), 16'd46);
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 9'd37, 9'd0));
    sel(9'd9);
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 9'd37, 9'd0));
      coin(2'b01);
      cmp("bp_change_held", 16'(change), 16'd37);
      cmp("bp_busy", 16'(busy), 16'd1);
    end
    change_ready = 1'b1;
    cyc();
    cmp("handshake_cv_drop", 16'(change_valid), 16'd0);
    cmp("after_sale_credit", 16'(credit), 16'd0);

    // Overflow reject at 490, then a dime reaches exactly the ceiling.
    for (int i = 0; i < 19; i++) coin(2'b11);
    coin(2'b10); coin(2'b01);
    cmp("credit_490", 16'(credit), 16'd490);
    sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 9'd490));
    coin(2'b11);
    coin(2'b10);
    cmp("credit_500", 16'(credit), 16'd500);

    // Cancel with ready already high: one-cycle CHANGE, coin accepted at N+2.
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 9'd500, 9'd0));
    cancel = 1'b1; cyc(); cancel = 1'b0;
    cmp("min_res_busy", 16'(busy), 16'd1);
    cyc();
    cmp("min_res_done", 16'(busy), 16'd0);
    coin(2'b11); coin(2'b01);
    cmp("credit_30", 16'(credit), 16'd30);

    // Deny then retry.
    sb_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 9'd30));
    sel(9'd50);
    coin(2'b11);
    cmp("credit_55", 16'(credit), 16'd55);
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 9'd5, 9'd0));
    sel(9'd50);
    cyc();

    // Cancel together with a nickel: coin rejected, full credit returned.
    coin(2'b11); coin(2'b10); coin(2'b01);
    cmp("credit_40", 16'(credit), 16'd40);
    sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 9'd40, 9'd0));
    cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'b01;
    cyc();
    cancel = 1'b0; coin_valid = 1'b0;
    cyc();

    // Zero-price vend at zero credit yields zero change.
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 9'd0, 9'd0));
    sel(9'd0);
    cyc();
`ifdef VEND_AUDIT_EN
    cmp("sales_total", sales_total, 16'd59);
    cmp("vend_count", 16'(vend_count), 16'd3);
`endif

    // Reset in the middle of a pending change.
    change_ready = 1'b0;
    coin(2'b11); coin(2'b10); coin(2'b10); coin(2'b00);
    sb_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 9'd37, 9'd0));
    sel(9'd9);
    cyc(); cyc();
    cmp("pre_rst_cv", 16'(change_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_cv", 16'(change_valid), 16'd0);
    cmp("async_rst_busy", 16'(busy), 16'd0);
    cmp("async_rst_credit", 16'(credit), 16'd0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Credit accumulator and sale controller for the vending datapath. Accepts validated coin strobes, keeps a running credit in cents, and on a product select or cancel computes the amount to return. It sits directly upstream of `dispenseChange`: its `change` output drives that block's 9-bit `change` input, held stable while `change_valid` is high.

## Interface

Parameters:
- `MAX_CREDIT`, 500: highest credit accepted, in cents. Must be ≤ 511.
- `CREDIT_W`, 9: width of credit, price and change.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `coin_valid`, input, 1: one-cycle strobe; a coin is present this cycle.
- `coin_type`, input, 2: coin denomination. 00 = penny (1), 01 = nickel (5), 10 = dime (10), 11 = quarter (25).
- `price`, input, `CREDIT_W`: item price in cents; sampled when `select` is high.
- `select`, input, 1: purchase request (level, sampled each cycle).
- `cancel`, input, 1: return all credit.
- `change_ready`, input, 1: downstream dispenser accepts `change`.
- `credit`, output, `CREDIT_W`: current accumulated credit.
- `coin_reject`, output, 1: one-cycle pulse; the coin was not accepted.
- `deny`, output, 1: one-cycle pulse; select arrived with credit < price.
- `vend`, output, 1: one-cycle pulse; a product is released.
- `change`, output, `CREDIT_W`: amount to return; held while `change_valid` is high.
- `change_valid`, output, 1: `change` is valid. Held until the handshake completes.
- `busy`, output, 1: high in the `CHANGE` state.

## Operation

The controller has two states, `COLLECT` and `CHANGE`.

Reset values: state = `COLLECT`; `credit`, `change` and all pulse/valid outputs = 0.

In `COLLECT`, events are resolved per cycle with priority cancel > select > coin:
- **cancel with credit ≠ 0:** `change` = credit, credit ← 0, go to `CHANGE`. No `vend`.
- **cancel with credit = 0:** no action.
- **select with credit ≥ price:** `vend` pulses, `change` = credit − price, credit ← 0, go to `CHANGE`. This includes the case `change` = 0.
- **select with credit < price:** `deny` pulses; credit is unchanged.
- **coin:** if credit + value ≤ `MAX_CREDIT`, credit ← credit + value. Otherwise `coin_reject` pulses and credit is unchanged.
- **coin in the same cycle that a cancel or successful select is acted on:** `coin_reject` pulses. A coin arriving alongside a denied select is processed normally.

In `CHANGE`:
- `change_valid` = 1 and `busy` = 1.
- When `change_ready` is sampled high, `change_valid` drops and the state returns to `COLLECT` on the next cycle.
- Every `coin_valid` produces `coin_reject`.
- `select` and `cancel` are ignored.

Arithmetic:
- Compute the sum at `CREDIT_W`+1 bits before comparing against `MAX_CREDIT`.
- The subtraction is unsigned and is performed only when credit ≥ price.

## Timing

- A coin strobe at edge N makes `credit` updated after N. `coin_reject` is high for the cycle after N.
- A select or cancel at edge N gives `vend`/`deny`, `change`, `change_valid` and `busy` valid in cycle N+1.
- The minimum `CHANGE` residency is 1 cycle, when `change_ready` is already high at edge N+1. A new coin is then accepted from edge N+2.
- All outputs are registered; there is no combinational path from input to output.
- Asserting `rst_n` low mid-transaction discards credit and pending change immediately: `change_valid` goes to 0 asynchronously.

## Configuration

- **`VEND_AUDIT_EN` defined:** adds two output ports.
  - `sales_total`, 16 bits: sum of prices of completed vends, saturating at 65535.
  - `vend_count`, 8 bits: count of `vend` pulses, wrapping.
  - Both reset to 0.
- **`VEND_AUDIT_EN` undefined:** neither port nor its logic exists. All other behaviour is identical.

## Structure

- The shared package `vend_pkg` holds:
  - the coin type codes;
  - the coin value constants (1/5/10/25);
  - the state enum (`COLLECT`, `CHANGE`);
  - the default `MAX_CREDIT`.
- One sub-module, `coin_value`: a combinational decode of `coin_type` to a 5-bit cent value.

## Test plan

- **Normal sale:** after reset, insert quarter, dime, dime, penny (credit 46), then select with price = 9. Expect `vend` = 1 pulse, `change` = 37, `change_valid` held until `change_ready`, `credit` = 0.
- **Overflow reject:** from credit 490, insert a quarter. Expect `coin_reject` pulse and credit stays 490. A following dime gives credit 500.
- **Deny then retry:** at credit 30, select with price 50 gives a `deny` pulse and credit 30. Add a quarter (55), then select again. Expect `vend` and `change` = 5.
- **Cancel with coin in the same cycle:** at credit 40, assert cancel and a nickel together. Expect `coin_reject`, `change` = 40, no `vend`.
- **Backpressure and reset:** hold `change_ready` low for 5 cycles; `change` stays 37 and coins are rejected. Then pulse `rst_n` low; `change_valid`, `credit` and `busy` go to 0 immediately.
- **Audit (`VEND_AUDIT_EN` defined):** run three vends at prices 9, 50 and 0. Expect `sales_total` = 59 and `vend_count` = 3.
